// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops a sync FIFO and serialises each byte as start, DATA_W bits LSB-first, stop.
// Define PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_enb,
  output logic              tx,
  output logic              busy,
  output logic              byte_done,
  output logic [7:0]        tx_count
);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_e;
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] BAUD_PRE  = 16'(CLKS_PER_BIT - 2);
  localparam logic [2:0]  IDX_LAST  = 3'(DATA_W - 1);
  state_e            state_q;
  logic [15:0]       baud_q, baud_d;
  logic [2:0]        idx_q;
  logic [DATA_W-1:0] shift_q;
  logic              tx_q, rd_q, busy_q, done_q;
  logic [7:0]        count_q;
  logic              baud_last, timing;
`ifdef PARITY_EN
  logic              par_q;
`endif
  assign timing    = state_q inside {START, DATA, PARITY, STOP};
  assign baud_last = baud_q == BAUD_LAST;
  // the baud counter restarts on every state entry and at each data-bit boundary
  assign baud_d    = (timing && !baud_last) ? baud_q + 16'd1 : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
`ifdef PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      baud_q <= baud_d;
      rd_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (tx_en && !fifo_empty) begin
          state_q <= FETCH;
          rd_q    <= 1'b1;
          busy_q  <= 1'b1;
        end
        FETCH: state_q <= LOAD;
        LOAD: begin
          shift_q <= fifo_rd_data;
`ifdef PARITY_EN
          par_q   <= ^fifo_rd_data;
`endif
          state_q <= START;
          tx_q    <= 1'b0;
        end
        START: if (baud_last) begin
          state_q <= DATA;
          idx_q   <= '0;
          tx_q    <= shift_q[0];
          shift_q <= shift_q >> 1;
        end
        DATA: if (baud_last) begin
          if (idx_q == IDX_LAST) begin
`ifdef PARITY_EN
            state_q <= PARITY;
            tx_q    <= par_q;
`else
            state_q <= STOP;
            tx_q    <= 1'b1;
`endif
          end else begin
            idx_q   <= idx_q + 3'd1;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
        end
`ifdef PARITY_EN
        PARITY: if (baud_last) begin
          state_q <= STOP;
          tx_q    <= 1'b1;
        end
`endif
        STOP: begin
          // done and the frame count land together on the final stop-bit cycle
          if (baud_q == BAUD_PRE) begin
            done_q  <= 1'b1;
            count_q <= count_q + 8'd1;
          end
          if (baud_last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign fifo_rd_enb = rd_q;
  assign tx          = tx_q;
  assign busy        = busy_q;
  assign byte_done   = done_q;
  assign tx_count    = count_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: randomized frame checks against a queue scoreboard and a behavioural FIFO.
module tb_fifo_uart_tx;
  localparam int CPB = 4;
`ifdef PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 1'b0, rst_n = 1'b0, tx_en = 1'b0;
  logic fifo_empty, fifo_rd_enb, tx, busy, byte_done;
  logic [7:0] fifo_rd_data = '0, tx_count;
  logic push_v = 1'b0;
  logic [7:0] push_d = '0;
  logic [7:0] mem [8];
  int rp = 0, wp = 0, fcnt = 0, underrun = 0;
  logic [7:0] sb [$];
  int tests = 0, fails = 0, exp_count = 0;

  fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_enb(fifo_rd_enb), .tx(tx),
    .busy(busy), .byte_done(byte_done), .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (fcnt == 0);
  always @(posedge clk) begin
    if (fifo_rd_enb) begin
      if (fcnt == 0) underrun <= underrun + 1;
      else begin
        fifo_rd_data <= mem[rp];
        rp <= (rp + 1) % 8;
      end
    end
    if (push_v) begin
      mem[wp] <= push_d;
      wp <= (wp + 1) % 8;
    end
    fcnt <= fcnt + (push_v ? 1 : 0) - ((fifo_rd_enb && fcnt > 0) ? 1 : 0);
  end

  task automatic push(input logic [7:0] b);
    push_d = b;
    push_v = 1'b1;
    sb.push_back(b);
    @(negedge clk);
    push_v = 1'b0;
  endtask

  task automatic wait_fetch(input string name, input int want);
    int n;
    n = 0;
    while (fifo_rd_enb !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 200 || (want >= 0 && n != want)) begin
      fails++;
      $display("FAIL %s fetch: waited %0d cycles, want %0d", name, n, want);
    end
  endtask

  // Entered on the FETCH-cycle negedge; returns on the last stop-bit cycle.
  task automatic check_frame(input string name, input int drop_at);
    logic [7:0] b;
    logic [10:0] e;
    logic de;
    int errs, cyc, bad_cyc;
    logic bad_tx, bad_exp;
    b = sb.size() > 0 ? sb.pop_front() : 8'h00;
    e = '0;
    for (int i = 0; i < 8; i++) e[i + 1] = b[i];
    e[9] = 1'b1;
`ifdef PARITY_EN
    e[9] = ($countones(b) % 2) == 1;
    e[10] = 1'b1;
`endif
    errs = 0; cyc = 0; bad_cyc = -1; bad_tx = 1'bx; bad_exp = 1'b1;
    if (tx !== 1'b1 || busy !== 1'b1) begin errs++; bad_cyc = 0; bad_tx = tx; end
    @(negedge clk);
    cyc = 1;
    if (tx !== 1'b1 || busy !== 1'b1 || fifo_rd_enb !== 1'b0) begin
      errs++;
      if (bad_cyc < 0) begin bad_cyc = 1; bad_tx = tx; end
    end
    for (int k = 0; k < NB; k++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        cyc++;
        if (cyc == drop_at) tx_en = 1'b0;
        de = (k == NB - 1) && (c == CPB - 1);
        if (tx !== e[k] || busy !== 1'b1 || fifo_rd_enb !== 1'b0 || byte_done !== de) begin
          errs++;
          if (bad_cyc < 0) begin bad_cyc = cyc; bad_tx = tx; bad_exp = e[k]; end
        end
      end
    end
    exp_count++;
    tests++;
    if (errs != 0) begin
      fails++;
      $display("FAIL %s frame %02h: %0d bad cycles, first at cycle %0d tx=%b want %b", name, b, errs, bad_cyc, bad_tx, bad_exp);
    end
    tests++;
    if (tx_count !== 8'(exp_count)) begin
      fails++;
      $display("FAIL %s tx_count: got %0d want %0d", name, tx_count, exp_count);
    end
  endtask

  task automatic settle();
    tx_en = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      fails++;
      $display("FAIL settle: busy=%b tx=%b want busy=0 tx=1", busy, tx);
    end
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || byte_done !== 1'b0 || fifo_rd_enb !== 1'b0 || tx_count !== 8'd0) begin
      fails++;
      $display("FAIL reset values: tx=%b busy=%b done=%b rd=%b cnt=%0d want 1,0,0,0,0", tx, busy, byte_done, fifo_rd_enb, tx_count);
    end
    rst_n = 1'b1;
    tx_en = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_enb !== 1'b0 || tx_count !== 8'd0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL empty idle: %0d bad cycles, want 0", bad);
    end
    tx_en = 1'b0;
  endtask

  task automatic test_single();
    push(8'hA5);
    tx_en = 1'b1;
    wait_fetch("single", -1);
    check_frame("single", -1);
    settle();
    tests++;
    if (fcnt != 0 || underrun != 0) begin
      fails++;
      $display("FAIL single fifo: count=%0d underrun=%0d want 0,0", fcnt, underrun);
    end
  endtask

  task automatic run_burst(input string name);
    int n;
    n = sb.size();
    tx_en = 1'b1;
    wait_fetch(name, -1);
    check_frame(name, -1);
    for (int i = 1; i < n; i++) begin
      wait_fetch(name, 2);
      check_frame(name, -1);
    end
    settle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    run_burst("b2b");
    tests++;
    if (tx_count !== 8'd9 || underrun != 0) begin
      fails++;
      $display("FAIL b2b totals: cnt=%0d underrun=%0d want 9,0", tx_count, underrun);
    end
  endtask

  task automatic test_random();
    int k;
    for (int r = 0; r < 3; r++) begin
      k = $urandom_range(1, 8);
      for (int i = 0; i < k; i++) push(8'($urandom));
      run_burst("random");
    end
  endtask

  task automatic test_tx_en_drop();
    int bad;
    push(8'h3C);
    push(8'($urandom));
    tx_en = 1'b1;
    wait_fetch("drop", -1);
    check_frame("drop", 10);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (fifo_rd_enb !== 1'b0 || busy !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0 || fcnt != 1) begin
      fails++;
      $display("FAIL drop hold: %0d bad cycles, fifo count=%0d want 0,1", bad, fcnt);
    end
    tx_en = 1'b1;
    wait_fetch("drop resume", -1);
    check_frame("drop resume", -1);
    settle();
  endtask

  task automatic test_reset_mid();
    push(8'($urandom));
    push(8'($urandom));
    tx_en = 1'b1;
    wait_fetch("midreset", -1);
    repeat (23) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || byte_done !== 1'b0 || fifo_rd_enb !== 1'b0 || tx_count !== 8'd0) begin
      fails++;
      $display("FAIL midreset async: tx=%b busy=%b done=%b rd=%b cnt=%0d want 1,0,0,0,0", tx, busy, byte_done, fifo_rd_enb, tx_count);
    end
    void'(sb.pop_front());
    exp_count = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_fetch("midreset resume", -1);
    check_frame("midreset resume", -1);
    settle();
  endtask

  task automatic test_parity();
    push(8'hA5);
    push(8'h07);
    run_burst("parity");
    tests++;
    if (underrun != 0 || fcnt != 0) begin
      fails++;
      $display("FAIL final fifo: underrun=%0d count=%0d want 0,0", underrun, fcnt);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_tx_en_drop();
    test_reset_mid();
    test_parity();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream drain stage for the 8-deep, 8-bit sync FIFO. Pops bytes whenever the FIFO is non-empty and transmitting is enabled, and serialises each byte onto a single UART-style line (start, 8 data LSB-first, stop). Turns the FIFO's parallel read port into a serial link. It is built so that it never causes a FIFO underrun.

Parameters:
DATA_W, 8, byte width; must match the FIFO data width.
CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..65535.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
tx_en  input  1  permission to start a new frame
fifo_empty  input  1  FIFO empty flag
fifo_rd_data  input  DATA_W  FIFO read data, valid the cycle after fifo_rd_enb is sampled high
fifo_rd_enb  output  1  FIFO pop strobe
tx  output  1  serial line, idle high
busy  output  1  high from fetch until end of stop bit
byte_done  output  1  one-cycle pulse on the last cycle of the stop bit
tx_count  output  8  frames completed, wraps 255->0

Behaviour:
- Reset (async, rst_n low): tx=1, fifo_rd_enb=0, busy=0, byte_done=0, tx_count=0, FSM=IDLE, bit/baud counters=0. All take effect immediately, mid-frame included. The partially sent byte is lost.
- FSM: IDLE -> FETCH -> LOAD -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: if tx_en=1 and fifo_empty=0, go to FETCH. Otherwise stay, with tx=1 and busy=0.
- FETCH: fifo_rd_enb=1 for exactly this one cycle; busy=1.
- LOAD: capture fifo_rd_data into the shift register; tx still 1.
- fifo_rd_enb is high only in FETCH and is never asserted while fifo_empty=1. A FIFO underrun caused by this block is a bug.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: bit 0 first. Each bit is held CLKS_PER_BIT cycles. A 3-bit index counts 0..7, then leaves the state.
- STOP: tx=1 for CLKS_PER_BIT cycles. On the last cycle: byte_done=1 and tx_count increments.
- Baud counter: reloads to 0 on every state entry; the state advances when the counter reaches CLKS_PER_BIT-1.
- Back-to-back: after STOP, IDLE lasts 1 cycle, then FETCH and LOAD follow. That gives exactly 3 idle-high cycles between frames; this gap is fixed.
- tx_en falling mid-frame: the current frame completes normally; no new fetch is made.
- FIFO becomes empty while busy: no effect on the current frame.
- busy=1 in every state except IDLE.
- Line pattern per frame: 1+8+1 bits. Frame length is 10*CLKS_PER_BIT cycles, plus 2 for fetch/load.

Optional Feature:
PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP. tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame is 11 bits.
- Undefined: no parity state; frame is 10 bits. Ports are identical in both builds.

Test Plan:
- Reset, CLKS_PER_BIT=4, FIFO empty, tx_en=1 for 50 cycles -> tx=1, fifo_rd_enb never 1, busy=0, tx_count=0.
- One byte 8'hA5 in FIFO, tx_en=1 -> fifo_rd_enb high 1 cycle, then the tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. byte_done pulses once; tx_count=1; FIFO empty afterwards, no underrun flag.
- 8 bytes 8'h10..8'h17 with FIFO full -> 8 frames in order, 3 idle-high cycles between frames, tx_count=8, fifo_underrun never set.
- tx_en dropped 10 cycles into a frame of 8'h3C with 2 bytes queued -> 8'h3C finishes and the second byte stays in the FIFO. Re-asserting tx_en sends it.
- rst_n pulsed low during DATA bit 4 -> tx=1 and busy=0 immediately. After release, the next queued byte is sent from a fresh start bit.
- PARITY_EN, bytes 8'hA5 then 8'h07 -> parity bits are 0 and 1; frames are 44 cycles each at CLKS_PER_BIT=4.
